// File: rtl/gauss_pkg.sv
// Shared types and helpers for the 3x3 gauss window sequencer.
// A window slot k is numbered row*3+col, so slot 4 is the centre pixel.
package gauss_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BORDER,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int WIN_SLOTS = 9;
  localparam int DEF_IMG_W = 320;
  localparam int DEF_IMG_H = 240;

  // Slot number for a (row, col) position inside the 3x3 window.
  function automatic logic [3:0] slot_idx(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'd3 + 4'(col);
  endfunction

  // Window row (0..2) of slot k.
  function automatic logic [1:0] slot_row(input logic [3:0] k);
    return (k >= 4'd6) ? 2'd2 : ((k >= 4'd3) ? 2'd1 : 2'd0);
  endfunction

  // Window column (0..2) of slot k.
  function automatic logic [1:0] slot_col(input logic [3:0] k);
    return 2'(k - 4'(slot_row(k)) * 4'd3);
  endfunction

endpackage

// File: rtl/gauss_addr_gen.sv
// Raster row/column counters for the gauss window sequencer.
// The border flag, write address and read address describe the pixel the
// counters will hold after the current edge, so the controller can register
// its outputs on the same edge that moves to a new pixel. last_o describes
// the pixel currently held.
module gauss_addr_gen
  import gauss_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 17
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              adv_i,
  input  logic [3:0]        slot_i,
  output logic              border_o,
  output logic              last_o,
  output logic              col_ge2_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic [ADDR_W-1:0] wr_addr_o
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0]     COL_MAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0]     ROW_MAX = RW'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] W_A     = ADDR_W'(IMG_W);

  logic [CW-1:0]     col_reg, col_next;
  logic [RW-1:0]     row_reg, row_next;
  logic [ADDR_W-1:0] base_reg, base_next;   // row_reg * IMG_W kept incrementally

  // Next raster position: clear to the origin, or step one pixel with row wrap.
  always_comb begin
    col_next  = col_reg;
    row_next  = row_reg;
    base_next = base_reg;
    if (clear_i) begin
      col_next  = '0;
      row_next  = '0;
      base_next = '0;
    end else if (adv_i) begin
      if (col_reg == COL_MAX) begin
        col_next  = '0;
        row_next  = row_reg + RW'(1);
        base_next = base_reg + W_A;
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  // Counter state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_reg  <= '0;
      row_reg  <= '0;
      base_reg <= '0;
    end else begin
      col_reg  <= col_next;
      row_reg  <= row_next;
      base_reg <= base_next;
    end
  end

  assign border_o  = (row_next == '0) || (row_next == ROW_MAX) ||
                     (col_next == '0) || (col_next == COL_MAX);
  assign last_o    = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
  assign col_ge2_o = (col_next >= CW'(2));
  assign wr_addr_o = base_next + ADDR_W'(col_next);
  // Slot k reads (r-1+k/3)*IMG_W + (c-1+k%3); interior pixels never underflow.
  assign rd_addr_o = wr_addr_o + ADDR_W'(slot_col(slot_i)) +
                     ADDR_W'(slot_row(slot_i)) * W_A - W_A - ADDR_W'(1);

endmodule

// File: rtl/gauss_window_ctrl.sv
// Raster sequencer that builds 3x3 windows for the gauss1 core and writes
// one result per pixel (zero on the frame border).
// Build option: GAUSS_WINDOW_REUSE_EN shifts the window left for interior
// columns >= 2 and fetches only the new right column (slots 2,5,8).
module gauss_window_ctrl
  import gauss_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          start_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          rd_en_o,
  output logic [ADDR_W-1:0]             rd_addr_o,
  input  logic [DATA_W-1:0]             rd_data_i,
  output logic [WIN_SLOTS*DATA_W-1:0]   win_o,
  output logic                          win_valid_o,
  input  logic                          core_done_i,
  input  logic [DATA_W-1:0]             core_data_i,
  output logic                          wr_en_o,
  output logic [ADDR_W-1:0]             wr_addr_o,
  output logic [DATA_W-1:0]             wr_data_o
);

`ifdef GAUSS_WINDOW_REUSE_EN
  localparam bit REUSE_EN = 1'b1;
`else
  localparam bit REUSE_EN = 1'b0;
`endif

  state_e            state_reg;
  logic              busy_reg, done_reg, rd_en_reg, wr_en_reg, win_valid_reg;
  logic [ADDR_W-1:0] rd_addr_reg, wr_addr_reg;
  logic [DATA_W-1:0] wr_data_reg;
  logic [DATA_W-1:0] win_reg [WIN_SLOTS];
  logic [3:0]        fetch_idx_reg;   // index of the read currently on the bus
  logic              reuse_reg;       // current fetch only loads slots 2,5,8
  logic [3:0]        rd_slot_reg;     // slot of the read currently on the bus
  logic              cap_pend_reg;    // read data arrives this cycle
  logic [3:0]        cap_slot_reg;

  logic              ag_border, ag_last, ag_col_ge2;
  logic [ADDR_W-1:0] ag_rd_addr, ag_wr_addr;

  logic       start_acc, pix_end, launch, adv;
  logic [3:0] next_idx, k_sel;
  logic       reuse_sel, fetch_last;

  // Pixel sequencing and the slot of the next read to be issued.
  always_comb begin
    start_acc  = (state_reg == ST_IDLE) && start_i;
    pix_end    = (state_reg == ST_BORDER) || (state_reg == ST_WRITE);
    launch     = start_acc || (pix_end && !ag_last);
    adv        = launch && !start_acc;
    next_idx   = launch ? 4'd0 : (fetch_idx_reg + 4'd1);
    reuse_sel  = launch ? (REUSE_EN && ag_col_ge2) : reuse_reg;
    k_sel      = reuse_sel ? slot_idx(next_idx[1:0], 2'd2) : next_idx;
    fetch_last = reuse_reg ? (fetch_idx_reg == 4'd2) : (fetch_idx_reg == 4'd8);
  end

  gauss_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (start_acc),
    .adv_i    (adv),
    .slot_i   (k_sel),
    .border_o (ag_border),
    .last_o   (ag_last),
    .col_ge2_o(ag_col_ge2),
    .rd_addr_o(ag_rd_addr),
    .wr_addr_o(ag_wr_addr)
  );

  // Main FSM with registered outputs, read-data capture and window shift.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= ST_IDLE;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      rd_en_reg     <= 1'b0;
      wr_en_reg     <= 1'b0;
      win_valid_reg <= 1'b0;
      rd_addr_reg   <= '0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= '0;
      fetch_idx_reg <= '0;
      reuse_reg     <= 1'b0;
      rd_slot_reg   <= '0;
      cap_pend_reg  <= 1'b0;
      cap_slot_reg  <= '0;
      for (int i = 0; i < WIN_SLOTS; i++) win_reg[i] <= '0;
    end else begin
      win_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      cap_pend_reg  <= rd_en_reg;
      cap_slot_reg  <= rd_slot_reg;
      if (cap_pend_reg) win_reg[cap_slot_reg] <= rd_data_i;

      if (launch) begin
        if (start_acc) busy_reg <= 1'b1;
        if (ag_border) begin
          state_reg   <= ST_BORDER;
          wr_en_reg   <= 1'b1;
          wr_addr_reg <= ag_wr_addr;
          wr_data_reg <= '0;
          rd_en_reg   <= 1'b0;
        end else begin
          state_reg     <= ST_FETCH;
          wr_en_reg     <= 1'b0;
          rd_en_reg     <= 1'b1;
          rd_addr_reg   <= ag_rd_addr;
          rd_slot_reg   <= k_sel;
          fetch_idx_reg <= 4'd0;
          reuse_reg     <= reuse_sel;
          if (reuse_sel) begin
            for (int r = 0; r < 3; r++) begin
              win_reg[slot_idx(2'(r), 2'd0)] <= win_reg[slot_idx(2'(r), 2'd1)];
              win_reg[slot_idx(2'(r), 2'd1)] <= win_reg[slot_idx(2'(r), 2'd2)];
            end
          end
        end
      end else begin
        case (state_reg)
          ST_FETCH: begin
            if (rd_en_reg) begin
              if (fetch_last) begin
                rd_en_reg <= 1'b0;
              end else begin
                rd_addr_reg   <= ag_rd_addr;
                rd_slot_reg   <= k_sel;
                fetch_idx_reg <= fetch_idx_reg + 4'd1;
              end
            end else begin
              // Last read data is captured on this edge.
              state_reg     <= ST_ISSUE;
              win_valid_reg <= 1'b1;
            end
          end
          ST_ISSUE: state_reg <= ST_WAIT;
          ST_WAIT: begin
            if (core_done_i) begin
              state_reg   <= ST_WRITE;
              wr_en_reg   <= 1'b1;
              wr_addr_reg <= ag_wr_addr;
              wr_data_reg <= core_data_i;
            end
          end
          ST_BORDER, ST_WRITE: begin
            // Only reached for the last pixel; other pixels launch the next.
            state_reg <= ST_DONE;
            wr_en_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
          ST_DONE:  state_reg <= ST_IDLE;
          default:  state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIN_SLOTS; gi++) begin : g_win
      assign win_o[gi*DATA_W +: DATA_W] = win_reg[gi];
    end
  endgenerate

  assign busy_o      = busy_reg;
  assign done_o      = done_reg;
  assign rd_en_o     = rd_en_reg;
  assign rd_addr_o   = rd_addr_reg;
  assign win_valid_o = win_valid_reg;
  assign wr_en_o     = wr_en_reg;
  assign wr_addr_o   = wr_addr_reg;
  assign wr_data_o   = wr_data_reg;

endmodule
